booth_seq_mult: RTL

Parametrised, iterative radix-4 Booth signed multiplier with valid/ready handshakes on both sides. It is the area-lean successor to the combinational 9-bit Booth/Dadda multiplier and computes one Booth digit per clock. It feeds the HPF filter datapath, where multiplier area matters more than throughput. An optional compile-time approximate mode truncates low partial-product columns for the approximate-computing experiments.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_pp_gen.sv | 47 ++++
 rtl/booth_seq_mult.sv | 91 +++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_dig_t;

  function automatic booth_dig_t booth_decode(input logic [2:0] g);
    booth_dig_t d;
    d.neg = g[2] & ~(g[1] & g[0]);
    d.one = g[1] ^ g[0];
    d.two = (g == 3'b011) | (g == 3'b100);
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Booth partial product: digit*x, sign-extended and shifted by 2*sh.
// Low TRUNC columns are zeroed when BOOTH_APPROX_EN is defined.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int TRUNC = 4,
  parameter int CW    = 3
) (
  input  logic [WIDTH-1:0]   x,
  input  booth_dig_t         d,
  input  logic [CW-1:0]      sh,
  output logic [2*WIDTH+1:0] pp
);

  localparam int AW = 2 * WIDTH + 2;

`ifdef BOOTH_APPROX_EN
  localparam int TZ = TRUNC;
`else
  localparam int TZ = 0 * TRUNC;
`endif

  localparam logic [AW-1:0] MASK =
    ~((AW'(1) << TZ) - AW'(1));

  logic signed [WIDTH+1:0] xs;
  logic signed [WIDTH+1:0] mag;
  logic signed [WIDTH+1:0] pv;
  logic        [AW-1:0]    pe;

  assign xs = {{2{x[WIDTH-1]}}, x};

  always_comb begin
    mag = '0;
    unique case (1'b1)
      d.two:   mag = xs <<< 1;
      d.one:   mag = xs;
      default: mag = '0;
    endcase
  end

  assign pv = d.neg ? -mag : mag;
  assign pe = AW'(pv);
  assign pp = (pe << {sh, 1'b0}) & MASK;

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth signed multiplier, one digit per clock.
// Optional BOOTH_APPROX_EN truncates the low TRUNC product columns.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int TRUNC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   mult
);

  localparam int N  = (WIDTH + 1) / 2;
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * WIDTH + 2;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   xq;
  logic [2*N:0]       yq;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      pp;
  logic [AW-1:0]      sum;
  logic [2:0]         grp;
  booth_dig_t         dig;
  logic [2*WIDTH-1:0] mult_q;

  // yq holds y sign-extended to 2N bits with the implicit y[-1]=0 at bit 0
  assign grp = yq[{count, 1'b0} +: 3];
  assign dig = booth_decode(grp);

  booth_pp_gen #(
    .WIDTH(WIDTH),
    .TRUNC(TRUNC),
    .CW   (CW)
  ) u_pp (
    .x (xq),
    .d (dig),
    .sh(count),
    .pp(pp)
  );

  assign sum = acc + pp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      xq     <= '0;
      yq     <= '0;
      acc    <= '0;
      mult_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xq    <= x;
            yq    <= {(2*N)'(signed'(y)), 1'b0};
            acc   <= '0;
            count <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= sum;
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            mult_q <= sum[2*WIDTH-1:0];
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mult      = mult_q;

endmodule
